ghost_motion_ctrl: RTL and testbench

- Downstream/feedback stage of the ghost AI. It owns the registered ghost position that feeds the ghost AI's previous-position inputs.
- It commits the AI's proposed next position once per move tick and reacts to the catch flag.
- It runs the round state machine: spawn, run, caught/freeze, game over.
- Outputs drive the renderer and the ghost AI.

---
 rtl/ghost_pkg.sv | 34 +++
 rtl/ghost_motion_ctrl_if.sv | 38 +++
 rtl/tick_divider.sv | 31 +++
 rtl/ghost_motion_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ghost_motion_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost movement path: round states,
// direction encoding, screen geometry and coordinate widths.
package ghost_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_CAUGHT = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_W = 2'd0,
        DIR_S = 2'd1,
        DIR_A = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;
    localparam int TILE   = 20;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    // Unsigned distance between two coordinates, zero-extended to 16 bits
    function automatic logic [15:0] abs_diff16(input logic [15:0] a, input logic [15:0] b);
        if (a >= b) begin
            abs_diff16 = a - b;
        end else begin
            abs_diff16 = b - a;
        end
    endfunction

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// Bus between the ghost AI / renderer side (master) and the motion controller (slave).
// step_err exists only when GHOST_STEP_CHECK_EN is defined.
interface ghost_motion_ctrl_if #(
    parameter int X_W = ghost_pkg::X_W,
    parameter int Y_W = ghost_pkg::Y_W
);
    logic           start;
    logic [X_W-1:0] next_x;
    logic [Y_W-1:0] next_y;
    logic [1:0]     next_dir;
    logic           is_over;
    logic [X_W-1:0] ghost_x;
    logic [Y_W-1:0] ghost_y;
    logic [1:0]     ghost_dir;
    logic           move_tick;
    logic [1:0]     lives;
    logic [1:0]     state;
    logic           game_over;
`ifdef GHOST_STEP_CHECK_EN
    logic           step_err;
`endif

    modport master (
        output start, next_x, next_y, next_dir, is_over,
        input  ghost_x, ghost_y, ghost_dir, move_tick, lives, state, game_over
`ifdef GHOST_STEP_CHECK_EN
        , input step_err
`endif
    );

    modport slave (
        input  start, next_x, next_y, next_dir, is_over,
        output ghost_x, ghost_y, ghost_dir, move_tick, lives, state, game_over
`ifdef GHOST_STEP_CHECK_EN
        , output step_err
`endif
    );
endinterface

// File: rtl/tick_divider.sv
// Free-running modulo-CLK_DIV counter; tick is high on the wrap cycle.
// Shared with the player position controller.
module tick_divider #(
    parameter int CLK_DIV = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Counter runs only while enabled; clear and disable both park it at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (r_cnt == LAST);
endmodule

// File: rtl/ghost_motion_ctrl.sv
// Ghost motion controller: commits AI-proposed positions on move ticks and runs
// the round FSM. Optional step legality check is built with GHOST_STEP_CHECK_EN.
module ghost_motion_ctrl #(
    parameter int CLK_DIV      = 2500000,
    parameter int SPAWN_X      = 300,
    parameter int SPAWN_Y      = 220,
    parameter int LIVES        = 3,
    parameter int FREEZE_TICKS = 20,
    parameter int X_W          = ghost_pkg::X_W,
    parameter int Y_W          = ghost_pkg::Y_W
`ifdef GHOST_STEP_CHECK_EN
    , parameter int MAX_STEP   = 5
`endif
) (
    input logic                clk,
    input logic                reset,
    ghost_motion_ctrl_if.slave bus
);
    import ghost_pkg::*;

    localparam int             FW        = $clog2(FREEZE_TICKS + 1);
    localparam logic [X_W-1:0] SPAWN_XV  = X_W'(SPAWN_X);
    localparam logic [Y_W-1:0] SPAWN_YV  = Y_W'(SPAWN_Y);
    localparam logic [1:0]     LIVES_V   = 2'(LIVES);
    localparam logic [FW-1:0]  FREEZE_V  = FW'(FREEZE_TICKS);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [1:0]     r_dir;
    logic           r_move_tick;
    logic [1:0]     r_lives;
    logic [FW-1:0]  r_freeze;
    logic           r_is_over_q;
    logic           r_game_over;
    logic           w_tick;
    logic           w_catch;
    logic           w_div_en;
    logic           w_div_clr;
    logic           w_commit_ok;

    assign w_catch   = bus.is_over & ~r_is_over_q;
    assign w_div_en  = (r_state == ST_RUN) || (r_state == ST_CAUGHT);
    assign w_div_clr = (r_state == ST_IDLE) && bus.start;

    tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (w_div_en),
        .clr   (w_div_clr),
        .tick  (w_tick)
    );

`ifdef GHOST_STEP_CHECK_EN
    logic [16:0] w_dist;
    logic        r_step_err;

    // Manhattan distance of the proposed move plus on-screen bound
    always_comb begin
        w_dist = {1'b0, abs_diff16(16'(bus.next_x), 16'(r_x))}
               + {1'b0, abs_diff16(16'(bus.next_y), 16'(r_y))};
        if ((w_dist <= 17'(MAX_STEP)) && (16'(bus.next_x) < 16'(WIDTH))
                && (16'(bus.next_y) < 16'(HEIGHT))) begin
            w_commit_ok = 1'b1;
        end else begin
            w_commit_ok = 1'b0;
        end
    end

    // Sticky rejection flag, cleared when a new game begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_step_err <= 1'b0;
        end else if ((r_state == ST_RUN) && !w_catch && w_tick && !w_commit_ok) begin
            r_step_err <= 1'b1;
        end else begin
            r_step_err <= r_step_err;
        end
    end

    assign bus.step_err = r_step_err;
`else
    assign w_commit_ok = 1'b1;
`endif

    // Round state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round state transitions; a catch is only acted on while running
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_RUN;
                else           w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_catch) begin
                    if (r_lives == 2'd1) w_state_nxt = ST_OVER;
                    else                 w_state_nxt = ST_CAUGHT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_CAUGHT: begin
                if (w_tick && (r_freeze == FW'(1))) w_state_nxt = ST_RUN;
                else                                 w_state_nxt = ST_CAUGHT;
            end
            ST_OVER: begin
                if (bus.start) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_OVER;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Position, lives and freeze bookkeeping; catch takes priority over commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x         <= SPAWN_XV;
            r_y         <= SPAWN_YV;
            r_dir       <= 2'd0;
            r_move_tick <= 1'b0;
            r_lives     <= LIVES_V;
            r_freeze    <= '0;
            r_is_over_q <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_is_over_q <= bus.is_over;
            r_move_tick <= w_tick;
            r_game_over <= (w_state_nxt == ST_OVER);
            case (r_state)
                ST_IDLE: begin
                    r_x      <= SPAWN_XV;
                    r_y      <= SPAWN_YV;
                    r_dir    <= 2'd0;
                    r_freeze <= '0;
                end
                ST_RUN: begin
                    if (w_catch) begin
                        r_lives <= r_lives - 2'd1;
                        if (r_lives != 2'd1) begin
                            r_x      <= SPAWN_XV;
                            r_y      <= SPAWN_YV;
                            r_freeze <= FREEZE_V;
                        end
                    end else if (w_tick && w_commit_ok) begin
                        r_x   <= bus.next_x;
                        r_y   <= bus.next_y;
                        r_dir <= bus.next_dir;
                    end
                end
                ST_CAUGHT: begin
                    r_x <= SPAWN_XV;
                    r_y <= SPAWN_YV;
                    if (w_tick) r_freeze <= r_freeze - FW'(1);
                end
                ST_OVER: begin
                    if (bus.start) r_lives <= LIVES_V;
                end
                default: begin
                    r_x <= SPAWN_XV;
                    r_y <= SPAWN_YV;
                end
            endcase
        end
    end

    assign bus.ghost_x   = r_x;
    assign bus.ghost_y   = r_y;
    assign bus.ghost_dir = r_dir;
    assign bus.move_tick = r_move_tick;
    assign bus.lives     = r_lives;
    assign bus.state     = r_state;
    assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// Scoreboard bench for ghost_motion_ctrl (CLK_DIV=4, FREEZE_TICKS=6);
// adds a step-check scenario when GHOST_STEP_CHECK_EN is defined.
module tb_ghost_motion_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [1:0] d;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    ghost_motion_ctrl_if #(.X_W(10), .Y_W(9)) bus ();

    ghost_motion_ctrl #(
        .CLK_DIV(4), .SPAWN_X(300), .SPAWN_Y(220), .LIVES(3),
        .FREEZE_TICKS(6), .X_W(10), .Y_W(9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int max_c, output int waited);
        waited = -1;
        for (int i = 1; i <= max_c; i++) begin
            cyc(1);
            if (bus.move_tick === 1'b1) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic set_next(input int x, input int y, input int d);
        bus.next_x   = 10'(x);
        bus.next_y   = 9'(y);
        bus.next_dir = 2'(d);
    endtask

    task automatic test_reset();
        int ticks;
        bus.start = 1'b0;
        bus.is_over = 1'b0;
        set_next(0, 0, 0);
        reset = 1'b0;
        cyc(3);
        n_vec++;
        if ({bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.move_tick, bus.lives, bus.state, bus.game_over}
                !== {10'd300, 9'd220, 2'd0, 1'b0, 2'd3, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_vals: got x=%0d y=%0d dir=%0d mt=%0d lives=%0d st=%0d go=%0d want 300 220 0 0 3 0 0",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.move_tick, bus.lives, bus.state, bus.game_over);
        end
        reset = 1'b1;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (bus.move_tick === 1'b1) ticks++;
        end
        n_vec++;
        if ({bus.state, 4'(ticks)} !== {2'd0, 4'd0}) begin
            n_err++;
            $display("FAIL idle_hold: got state=%0d ticks=%0d want 0 0", bus.state, ticks);
        end
    endtask

    task automatic test_commit();
        int w;
        int tx[3] = '{305, 306, 306};
        int ty[3] = '{220, 221, 222};
        int td[3] = '{3, 1, 2};
        for (int i = 0; i < 3; i++) begin
            set_next(tx[i], ty[i], td[i]);
            sb_q.push_back({10'(tx[i]), 9'(ty[i]), 2'(td[i])});
            if (i == 0) bus.start = 1'b1;
            wait_tick(8, w);
            bus.start = 1'b0;
            n_vec++;
            if (w !== ((i == 0) ? 5 : 3)) begin
                n_err++;
                $display("FAIL tick_period[%0d]: got %0d cycles want %0d", i, w, (i == 0) ? 5 : 3);
            end
            e = sb_q.pop_front();
            n_vec++;
            if ({bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.state} !== {e, 2'd1}) begin
                n_err++;
                $display("FAIL commit[%0d]: got %0d,%0d dir %0d st %0d want %0d,%0d dir %0d st 1",
                         i, bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.state, e.x, e.y, e.d);
            end
            cyc(1);
            n_vec++;
            if (bus.move_tick !== 1'b0) begin
                n_err++;
                $display("FAIL tick_width[%0d]: got %0b want 0", i, bus.move_tick);
            end
        end
    endtask

    task automatic test_catch_sticky();
        int first_run;
        first_run = -1;
        set_next(300, 220, 2);
        bus.is_over = 1'b1;
        cyc(1);
        n_vec++;
        if ({bus.lives, bus.state, bus.ghost_x, bus.ghost_y} !== {2'd2, 2'd2, 10'd300, 9'd220}) begin
            n_err++;
            $display("FAIL catch: got lives=%0d st=%0d pos=%0d,%0d want 2 2 300,220",
                     bus.lives, bus.state, bus.ghost_x, bus.ghost_y);
        end
        for (int i = 1; i < 100; i++) begin
            cyc(1);
            if (first_run < 0 && bus.state === 2'd1) first_run = i;
            if (i == 10) begin
                n_vec++;
                if ({bus.state, bus.ghost_x, bus.ghost_y} !== {2'd2, 10'd300, 9'd220}) begin
                    n_err++;
                    $display("FAIL freeze_hold: got st=%0d pos=%0d,%0d want 2 300,220",
                             bus.state, bus.ghost_x, bus.ghost_y);
                end
            end
        end
        bus.is_over = 1'b0;
        n_vec++;
        if (first_run !== 22) begin
            n_err++;
            $display("FAIL freeze_len: got RUN after %0d cycles want 22", first_run);
        end
        n_vec++;
        if ({bus.lives, bus.state} !== {2'd2, 2'd1}) begin
            n_err++;
            $display("FAIL sticky_once: got lives=%0d st=%0d want 2 1", bus.lives, bus.state);
        end
    endtask

    task automatic test_tick_catch();
        int w;
        set_next(303, 222, 2);
        sb_q.push_back({10'd303, 9'd222, 2'd2});
        wait_tick(8, w);
        e = sb_q.pop_front();
        n_vec++;
        if (w < 0 || {bus.ghost_x, bus.ghost_y, bus.ghost_dir} !== e) begin
            n_err++;
            $display("FAIL pre_catch: got %0d,%0d dir %0d (wait %0d) want %0d,%0d dir %0d",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, w, e.x, e.y, e.d);
        end
        cyc(3);
        bus.is_over = 1'b1;
        set_next(400, 100, 1);
        sb_q.push_back({10'd300, 9'd220, 2'd2});
        cyc(1);
        set_next(300, 220, 2);
        e = sb_q.pop_front();
        n_vec++;
        if ({bus.move_tick, bus.ghost_x, bus.ghost_y, bus.ghost_dir} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL tick_catch: got mt=%0d %0d,%0d dir %0d want mt=1 %0d,%0d dir %0d",
                     bus.move_tick, bus.ghost_x, bus.ghost_y, bus.ghost_dir, e.x, e.y, e.d);
        end
        n_vec++;
        if ({bus.lives, bus.state} !== {2'd1, 2'd2}) begin
            n_err++;
            $display("FAIL tick_catch_lives: got lives=%0d st=%0d want 1 2", bus.lives, bus.state);
        end
        bus.is_over = 1'b0;
        cyc(2);
        bus.is_over = 1'b1;
        cyc(2);
        bus.is_over = 1'b0;
        n_vec++;
        if ({bus.lives, bus.state} !== {2'd1, 2'd2}) begin
            n_err++;
            $display("FAIL caught_ignore: got lives=%0d st=%0d want 1 2", bus.lives, bus.state);
        end
        w = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (bus.state === 2'd1) begin
                w = i;
                break;
            end
        end
        n_vec++;
        if (w < 0) begin
            n_err++;
            $display("FAIL resume_run: got state=%0d after 40 cycles want 1", bus.state);
        end
    endtask

    task automatic test_game_over();
        int w;
        int ticks;
        set_next(302, 223, 1);
        sb_q.push_back({10'd302, 9'd223, 2'd1});
        wait_tick(8, w);
        e = sb_q.pop_front();
        n_vec++;
        if (w < 0 || {bus.ghost_x, bus.ghost_y, bus.ghost_dir} !== e) begin
            n_err++;
            $display("FAIL last_commit: got %0d,%0d dir %0d (wait %0d) want %0d,%0d dir %0d",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, w, e.x, e.y, e.d);
        end
        bus.is_over = 1'b1;
        cyc(1);
        bus.is_over = 1'b0;
        n_vec++;
        if ({bus.state, bus.game_over, bus.lives, bus.ghost_x, bus.ghost_y, bus.ghost_dir}
                !== {2'd3, 1'b1, 2'd0, 10'd302, 9'd223, 2'd1}) begin
            n_err++;
            $display("FAIL over: got st=%0d go=%0d lives=%0d %0d,%0d dir %0d want 3 1 0 302,223 dir 1",
                     bus.state, bus.game_over, bus.lives, bus.ghost_x, bus.ghost_y, bus.ghost_dir);
        end
        set_next(500, 400, 3);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.move_tick === 1'b1) ticks++;
        end
        n_vec++;
        if ({4'(ticks), bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.lives}
                !== {4'd0, 10'd302, 9'd223, 2'd1, 2'd0}) begin
            n_err++;
            $display("FAIL over_frozen: got ticks=%0d %0d,%0d dir %0d lives %0d want 0 302,223 dir 1 lives 0",
                     ticks, bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.lives);
        end
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        n_vec++;
        if ({bus.state, bus.lives, bus.game_over} !== {2'd0, 2'd3, 1'b0}) begin
            n_err++;
            $display("FAIL restart: got st=%0d lives=%0d go=%0d want 0 3 0", bus.state, bus.lives, bus.game_over);
        end
        cyc(1);
        n_vec++;
        if ({bus.state, bus.ghost_x, bus.ghost_y, bus.ghost_dir} !== {2'd0, 10'd300, 9'd220, 2'd0}) begin
            n_err++;
            $display("FAIL idle_spawn: got st=%0d %0d,%0d dir %0d want 0 300,220 dir 0",
                     bus.state, bus.ghost_x, bus.ghost_y, bus.ghost_dir);
        end
    endtask

    task automatic test_reset_mid_caught();
        set_next(300, 220, 3);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.is_over = 1'b1;
        cyc(1);
        bus.is_over = 1'b0;
        cyc(1);
        bus.is_over = 1'b1;
        cyc(2);
        bus.is_over = 1'b0;
        n_vec++;
        if ({bus.state, bus.lives, bus.move_tick} !== {2'd2, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL mid_caught: got st=%0d lives=%0d mt=%0d want 2 2 1", bus.state, bus.lives, bus.move_tick);
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.move_tick, bus.lives, bus.state, bus.game_over}
                !== {10'd300, 9'd220, 2'd0, 1'b0, 2'd3, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got x=%0d y=%0d dir=%0d mt=%0d lives=%0d st=%0d go=%0d want 300 220 0 0 3 0 0",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.move_tick, bus.lives, bus.state, bus.game_over);
        end
        #3;
        reset = 1'b1;
        cyc(1);
        n_vec++;
        if (bus.state !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset: got st=%0d want 0", bus.state);
        end
    endtask

`ifdef GHOST_STEP_CHECK_EN
    task automatic test_step();
        int w;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        n_vec++;
        if ({bus.state, bus.step_err} !== {2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL step_start: got st=%0d err=%0d want 1 0", bus.state, bus.step_err);
        end
        set_next(310, 220, 3);
        sb_q.push_back({10'd300, 9'd220, 2'd0});
        wait_tick(8, w);
        e = sb_q.pop_front();
        n_vec++;
        if (w < 0 || {bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.step_err} !== {e, 1'b1}) begin
            n_err++;
            $display("FAIL step_reject: got %0d,%0d dir %0d err %0d want %0d,%0d dir %0d err 1",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.step_err, e.x, e.y, e.d);
        end
        set_next(305, 220, 3);
        sb_q.push_back({10'd305, 9'd220, 2'd3});
        wait_tick(8, w);
        e = sb_q.pop_front();
        n_vec++;
        if (w < 0 || {bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.step_err} !== {e, 1'b1}) begin
            n_err++;
            $display("FAIL step_legal: got %0d,%0d dir %0d err %0d want %0d,%0d dir %0d err 1",
                     bus.ghost_x, bus.ghost_y, bus.ghost_dir, bus.step_err, e.x, e.y, e.d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_commit();
        test_catch_sticky();
        test_tick_catch();
        test_game_over();
        test_reset_mid_caught();
`ifdef GHOST_STEP_CHECK_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
